// File: rtl/multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control : fetch/decode/execute/memory/writeback sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCwrite,
  output logic       PcSrc,
  output logic       IRwrite,
  output logic       MemRead,
  output logic       Wr,
  output logic       AdrSrc,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] ALUFct,
  output logic       RegWrite,
  output logic [1:0] WbSel,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] S_INIT    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADDR = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXECR   = 4'd7;
  localparam logic [3:0] S_EXECI   = 4'd8;
  localparam logic [3:0] S_ALUWB   = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JAL     = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd15;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] FCT_ADD   = 3'b001;
  localparam logic [2:0] FCT_SUB   = 3'b010;
  localparam logic [2:0] FCT_AND   = 3'b011;
  localparam logic [2:0] FCT_OR    = 3'b100;
  localparam logic [2:0] FCT_XOR   = 3'b101;
  localparam logic [2:0] FCT_SLT   = 3'b110;
  localparam logic [2:0] FCT_PASSB = 3'b111;

  logic [3:0] state_q, state_d;
  logic [3:0] w_r_dec, w_i_dec;
  logic       w_is_lui, w_br_ok;

  // Returns {valid, ALU function} for the shared Funct3 map.
  function automatic logic [3:0] f3_map(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_map = {1'b1, FCT_ADD};
      3'b111:  f3_map = {1'b1, FCT_AND};
      3'b110:  f3_map = {1'b1, FCT_OR};
      3'b100:  f3_map = {1'b1, FCT_XOR};
      3'b010:  f3_map = {1'b1, FCT_SLT};
      default: f3_map = 4'b0000;
    endcase
  endfunction

  assign w_r_dec  = (Funct3 == 3'b000) ? {1'b1, (Funct7b5 ? FCT_SUB : FCT_ADD)}
                                       : f3_map(Funct3);
  assign w_i_dec  = f3_map(Funct3);
  assign w_is_lui = (Opcode == OP_LUI);
  assign w_br_ok  = (Funct3 == 3'b000) || (Funct3 == 3'b001);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:    state_d = S_FETCH;
      S_FETCH:   if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_R:              state_d = S_EXECR;
          OP_I, OP_LUI:      state_d = S_EXECI;
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXECR:   state_d = w_r_dec[3] ? S_ALUWB : S_TRAP;
      S_EXECI:   state_d = (w_is_lui || w_i_dec[3]) ? S_ALUWB : S_TRAP;
      S_ALUWB:   state_d = S_FETCH;
      S_MEMADDR: state_d = (Opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (MemReady) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (MemReady) state_d = S_FETCH;
      S_BRANCH:  state_d = w_br_ok ? S_FETCH : S_TRAP;
      S_JAL:     state_d = S_FETCH;
      default:   state_d = S_TRAP;
    endcase
  end

  always_comb begin
    PCwrite  = 1'b0;
    PcSrc    = 1'b0;
    IRwrite  = 1'b0;
    MemRead  = 1'b0;
    Wr       = 1'b0;
    AdrSrc   = 1'b0;
    AluSrcA  = 2'b00;
    AluSrcB  = 2'b00;
    ALUFct   = 3'b000;
    RegWrite = 1'b0;
    WbSel    = 2'b00;
    Illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        ALUFct  = FCT_ADD;
        IRwrite = MemReady;
        PCwrite = MemReady;
      end
      S_DECODE: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b11;
        ALUFct  = FCT_ADD;
      end
      S_EXECR: begin
        AluSrcA = 2'b01;
        ALUFct  = w_r_dec[2:0];
      end
      S_EXECI: begin
        AluSrcB = 2'b10;
        if (w_is_lui) begin
          ALUFct = FCT_PASSB;
        end else begin
          AluSrcA = 2'b01;
          ALUFct  = w_i_dec[2:0];
        end
      end
      S_ALUWB:   RegWrite = 1'b1;
      S_MEMADDR: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b10;
        ALUFct  = FCT_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        WbSel    = 2'b01;
      end
      S_MEMWR: begin
        Wr     = 1'b1;
        AdrSrc = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA = 2'b01;
        ALUFct  = FCT_SUB;
        PcSrc   = 1'b1;
        // beq takes on Zero, bne on !Zero; other Funct3 never writes PC.
        PCwrite = (Funct3 == 3'b000) ? Zero :
                  (Funct3 == 3'b001) ? ~Zero : 1'b0;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        WbSel    = 2'b10;
        PCwrite  = 1'b1;
        PcSrc    = 1'b1;
      end
      S_TRAP:  Illegal = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule
`default_nettype wire
